// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path:
//   - scan-code prefix constants (extended, break, Pause) and the number of
//     bytes that follow an E1 Pause prefix and must be swallowed
//   - frame-reception state encoding
//   - odd-parity helper used when the stop bit is checked
// ---------------------------------------------------------------------------
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frame_state_t;

   // PS/2 uses odd parity: data bits plus parity bit hold an odd count of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
// Receives one PS/2 frame at a time from the raw device-driven pins.
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   ps2_clk   in   PS/2 clock pin (asynchronous)
//   ps2_data  in   PS/2 data pin (asynchronous)
//   rx_byte   out  last correctly received byte (valid with byte_rdy)
//   byte_rdy  out  one-cycle pulse: rx_byte holds a good frame
//   err       out  one-cycle pulse: start/parity/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_rx
   import ps2_pkg::*;
#(
   parameter real CLK_FREQ      = 96.0,
   parameter int  FILTER_CYCLES = 8,
   parameter int  TIMEOUT_US    = 200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_rdy,
   output logic       err
);

   localparam int TO_CYC = $rtoi(CLK_FREQ * TIMEOUT_US + 0.5);
   localparam int TO_W   = $clog2(TO_CYC + 1);
   localparam int FC_W   = $clog2(FILTER_CYCLES + 1);

   logic [1:0]      clk_sync_p0;
   logic [1:0]      data_sync_p0;
   logic            clk_filt_p1;
   logic            clk_filt_p2;
   logic [FC_W-1:0] filt_cnt;
   logic            sample;
   logic            sdata;

   frame_state_t    state;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            par;
   logic [TO_W-1:0] wdog;

   // Stage p0: two-flop synchronisers. Stage p1: glitch filter on the clock;
   // a level change is only accepted after FILTER_CYCLES consecutive samples
   // disagree with the current filtered level. Stage p2: delayed copy for
   // falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync_p0  <= 2'b11;
         data_sync_p0 <= 2'b11;
         clk_filt_p1  <= 1'b1;
         clk_filt_p2  <= 1'b1;
         filt_cnt     <= '0;
      end else begin
         clk_sync_p0  <= {clk_sync_p0[0], ps2_clk};
         data_sync_p0 <= {data_sync_p0[0], ps2_data};
         clk_filt_p2  <= clk_filt_p1;
         if (clk_sync_p0[1] != clk_filt_p1) begin
            if (filt_cnt == FC_W'(FILTER_CYCLES - 1)) begin
               clk_filt_p1 <= clk_sync_p0[1];
               filt_cnt    <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign sample = clk_filt_p2 & ~clk_filt_p1;
   assign sdata  = data_sync_p0[1];

   // Frame FSM and inter-edge watchdog. A sample event always wins over an
   // expiring watchdog, so a late-but-valid edge still completes the frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         wdog     <= '0;
         rx_byte  <= '0;
         byte_rdy <= 1'b0;
         err      <= 1'b0;
      end else begin
         byte_rdy <= 1'b0;
         err      <= 1'b0;
         if (sample) begin
            wdog <= TO_W'(TO_CYC);
            case (state)
               IDLE: begin
                  if (!sdata) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg   <= {sdata, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= sdata;
                  state <= STOP;
               end
               STOP: begin
                  if (sdata && odd_parity_ok(shreg, par)) begin
                     rx_byte  <= shreg;
                     byte_rdy <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (wdog == '0) begin
               state <= IDLE;
               err   <= 1'b1;
            end else begin
               wdog <= wdog - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_key_encoder.sv
// ---------------------------------------------------------------------------
// ps2_key_encoder
// Turns the PS/2 keyboard stream into the 11-bit key word used by the control
// decoder: {toggle, pressed, extended, code}.
//   clk         in   system clock (clk_sys)
//   reset_n     in   asynchronous active-low reset
//   ps2_clk     in   PS/2 clock pin
//   ps2_data    in   PS/2 data pin
//   ps2_key     out  [10] toggle, [9] pressed, [8] extended, [7:0] scan code
//   key_strobe  out  one-cycle pulse in the cycle ps2_key changes
//   frame_err   out  one-cycle pulse on any frame error or timeout
// Consumers detect a new key event by watching ps2_key[10] flip.
// ---------------------------------------------------------------------------
module ps2_key_encoder
   import ps2_pkg::*;
#(
   parameter real CLK_FREQ      = 96.0,
   parameter int  FILTER_CYCLES = 8,
   parameter int  TIMEOUT_US    = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_strobe,
   output logic        frame_err
);

   logic [7:0] rx_byte;
   logic       byte_rdy;
   logic       rx_err;
   logic       ext;
   logic       brk;
   logic [2:0] skip;

   ps2_rx #(
      .CLK_FREQ      (CLK_FREQ),
      .FILTER_CYCLES (FILTER_CYCLES),
      .TIMEOUT_US    (TIMEOUT_US)
   ) u_rx (
      .clk      (clk),
      .reset_n  (reset_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_rdy (byte_rdy),
      .err      (rx_err)
   );

   assign frame_err = rx_err;

   // Prefix decoder and output register. A frame error wipes all pending
   // prefix and Pause-skip state so a half-received sequence cannot leak out
   // as a wrong key.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps2_key    <= '0;
         key_strobe <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         skip       <= '0;
      end else begin
         key_strobe <= 1'b0;
         if (rx_err) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
         end else if (byte_rdy) begin
            if (skip != '0) begin
               skip <= skip - 1'b1;
            end else begin
               case (rx_byte)
                  PS2_PAUSE: skip <= PAUSE_SKIP;
                  PS2_EXT:   ext  <= 1'b1;
                  PS2_BRK:   brk  <= 1'b1;
                  default: begin
                     ps2_key    <= {~ps2_key[10], ~brk, ext, rx_byte};
                     key_strobe <= 1'b1;
                     ext        <= 1'b0;
                     brk        <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_encoder.sv
`timescale 1ns/1ps
module tb_ps2_key_encoder;

   // 1 MHz system clock keeps a 12.5 kHz PS/2 frame to ~900 cycles.
   localparam int HALF = 40;            // PS/2 half period in clk cycles
   localparam int LAT  = 2 + 8 + 2;     // sync + filter + decode latency

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic        frame_err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int stop_fall_cyc = 0;
   int err_cnt = 0;
   int e0;
   logic prev_strobe = 1'b0;
   logic [10:0] exp_q[$];
   logic [7:0]  pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   ps2_key_encoder #(
      .CLK_FREQ      (1.0),
      .FILTER_CYCLES (8),
      .TIMEOUT_US    (200)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .ps2_key    (ps2_key),
      .key_strobe (key_strobe),
      .frame_err  (frame_err)
   );

   always #500 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest expected key.
   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_err === 1'b1) err_cnt++;
         if (prev_strobe) chk("strobe_width", 32'(key_strobe), 32'd0);
         if (key_strobe === 1'b1) begin
            chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               chk("key_value", 32'(ps2_key), 32'(exp_q.pop_front()));
               chk("strobe_latency", 32'(cyc - stop_fall_cyc), 32'(LAT));
            end
         end
      end
      prev_strobe = key_strobe;
   end

   task automatic ps2_bit(input logic b, input bit is_stop);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (is_stop) stop_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic bad_par);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
      ps2_bit((~^b) ^ bad_par, 1'b0);
      ps2_bit(1'b1, 1'b1);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_key(input logic [7:0] b, input logic [10:0] exp);
      exp_q.push_back(exp);
      send(b, 1'b0);
   endtask

   task automatic partial(input logic [7:0] b, input int nbits);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
   endtask

   task automatic drained(input string tag);
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      // reset state
      repeat (5) @(negedge clk);
      chk("reset_key", 32'(ps2_key), 32'd0);
      chk("reset_strobe", 32'(key_strobe), 32'd0);
      chk("reset_err", 32'(frame_err), 32'd0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);

      // plain make code
      send_key(8'h1C, 11'b1_1_0_00011100);
      drained("make_1c_drained");

      // break code
      send(8'hF0, 1'b0);
      send_key(8'h1C, 11'b0_0_0_00011100);
      drained("break_1c_drained");

      // extended make, then extended break with E0 before F0
      send(8'hE0, 1'b0);
      send_key(8'h75, 11'b1_1_1_01110101);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send_key(8'h75, 11'b0_0_1_01110101);
      drained("ext_75_drained");

      // Pause sequence is swallowed entirely
      for (int i = 0; i < 8; i++) send(pause_seq[i], 1'b0);
      send_key(8'h29, 11'b1_1_0_00101001);
      drained("pause_drained");

      // bad parity
      e0 = err_cnt;
      send(8'h29, 1'b1);
      chk("parity_err_count", 32'(err_cnt - e0), 32'd1);
      chk("parity_key_hold", 32'(ps2_key), 32'(11'b1_1_0_00101001));

      // E0 then a stalled frame: timeout must drop the pending extended flag
      send(8'hE0, 1'b0);
      e0 = err_cnt;
      partial(8'h55, 3);
      ps2_data = 1'b1;
      repeat (250) @(negedge clk);
      chk("timeout_err_count", 32'(err_cnt - e0), 32'd1);
      send_key(8'h6B, 11'b0_1_0_01101011);
      drained("timeout_drained");

      // reset in the middle of a frame
      partial(8'h16, 5);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("midreset_key", 32'(ps2_key), 32'd0);
      chk("midreset_strobe", 32'(key_strobe), 32'd0);
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      send_key(8'h16, 11'b1_1_0_00010110);
      drained("after_reset_drained");

      chk("err_total", 32'(err_cnt), 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
